// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   PC_W / INST_W     : program-counter and instruction-word widths
//   SEL_*             : redirect_sel encodings driven by ID
//   fetch_state_e     : fetch sequencer states
//   q_entry_t         : one prefetch-queue slot {instruction, pc}
//   branch_target()   : PC-relative branch target with zero-extended offset
package fetch_stage_pkg;

  localparam int PC_W   = 12;
  localparam int INST_W = 19;

  localparam logic [1:0] SEL_NONE   = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_RET    = 2'b11;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } q_entry_t;

  // Offset is an unsigned 8-bit forward displacement from the next PC;
  // the sum wraps modulo 2**PC_W.
  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc,
                                                     input logic [7:0]      offset);
    return pc + PC_W'(1) + {4'b0000, offset};
  endfunction

endpackage

// File: rtl/fetch_stage_ret_addr_stack.sv
// ret_addr_stack: circular return-address stack.
//   clk, reset     : clock, asynchronous active-high reset (empties the stack)
//   push_i         : push push_data_i; when full the oldest entry is overwritten
//   push_data_i    : return address to push
//   pop_i          : pop the top entry; popping an empty stack is flagged
//   top_o          : current top of stack (0 when empty)
//   overflow_o     : sticky, set by a push while full
//   underflow_o    : sticky, set by a pop while empty
module ret_addr_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] top_o,
  output logic         overflow_o,
  output logic         underflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;      // next slot to write; top lives one below
  logic [AW-1:0] top_idx;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          underflow_q;
  logic          empty;
  logic          full;

  assign empty       = (count_q == '0);
  assign full        = (count_q == (AW+1)'(DEPTH));
  assign top_idx     = wr_ptr_q - AW'(1);
  assign top_o       = empty ? '0 : mem_q[top_idx];
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (push_i) begin
      // When full the pointer still advances, so the write lands on the
      // oldest entry and the depth stays saturated.
      wr_ptr_q <= wr_ptr_q + AW'(1);
      if (full) overflow_q <= 1'b1;
      else      count_q    <= count_q + (AW+1)'(1);
    end else if (pop_i) begin
      if (empty) begin
        underflow_q <= 1'b1;
      end else begin
        wr_ptr_q <= top_idx;
        count_q  <= count_q - (AW+1)'(1);
      end
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count_q,
  // so stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end feeding the IF/ID register.
//   clk, reset           : clock, asynchronous active-high reset
//   imem_req/imem_addr   : fetch request, address held stable until imem_ack
//   imem_ack/imem_rdata  : read data valid (may arrive in the request cycle)
//   if_instruction/if_pc/if_valid : head of the 2-entry show-ahead queue
//   if_stall             : consumer hold; head is not popped
//   redirect/redirect_sel/redirect_call/id_pc/id_imm : redirect from ID
//   ras_overflow/ras_underflow : sticky return-address-stack error flags
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 12'h000,
  parameter int              RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] if_instruction,
  output logic [PC_W-1:0]   if_pc,
  output logic              if_valid,
  input  logic              if_stall,
  input  logic              redirect,
  input  logic [1:0]        redirect_sel,
  input  logic              redirect_call,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [PC_W-1:0]   id_imm,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] target_q, target_d;     // redirect target held during DRAIN
  q_entry_t        ent_q [2];
  q_entry_t        ent_d [2];
  logic [1:0]      count_q, count_d;

  logic            redir;
  logic [PC_W-1:0] redir_target;
  logic            ras_push;
  logic            ras_pop;
  logic [PC_W-1:0] ras_top;
  logic            req;
  logic            push;
  logic            pop;

  // A redirect with sel=00 is not a redirect at all.
  assign redir    = redirect && (redirect_sel != SEL_NONE);
  assign ras_push = redir && (redirect_sel == SEL_JUMP) && redirect_call;
  assign ras_pop  = redir && (redirect_sel == SEL_RET);

  ret_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (ras_push),
    .push_data_i (id_pc + PC_W'(1)),
    .pop_i       (ras_pop),
    .top_o       (ras_top),
    .overflow_o  (ras_overflow),
    .underflow_o (ras_underflow)
  );

  always_comb begin
    redir_target = '0;
    unique case (redirect_sel)
      SEL_BRANCH: redir_target = branch_target(id_pc, id_imm[7:0]);
      SEL_JUMP:   redir_target = id_imm;
      SEL_RET:    redir_target = ras_top;
      default:    redir_target = '0;
    endcase
  end

  // DRAIN keeps the outstanding request alive; in FETCH a request is made
  // only while the queue has room. Reset gates the port combinationally so
  // the request drops the instant reset is asserted.
  assign req       = (state_q == DRAIN) || (count_q != 2'd2);
  assign imem_req  = req && !reset;
  assign imem_addr = reset ? '0 : fetch_pc_q;

  assign push = (state_q == FETCH) && req && imem_ack && !redir;
  assign pop  = (count_q != 2'd0) && !if_stall;

  // NOTE: every variable driven here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    unique case (state_q)
      FETCH: begin
        if (redir) begin
          if (req && !imem_ack) begin
            state_d  = DRAIN;
            target_d = redir_target;
          end else begin
            fetch_pc_d = redir_target;
          end
        end else if (req && imem_ack) begin
          fetch_pc_d = fetch_pc_q + PC_W'(1);
        end
      end
      DRAIN: begin
        if (redir) target_d = redir_target;
        // The acknowledged word belongs to the abandoned path and is dropped.
        if (imem_ack) begin
          state_d    = FETCH;
          fetch_pc_d = redir ? redir_target : target_q;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Queue slot 0 is always the head. A pop shifts slot 1 down; a push then
  // lands in the first free slot after that shift.
  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    if (redir) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        ent_d[0] = ent_q[1];
        count_d  = count_q - 2'd1;
      end
      if (push) begin
        ent_d[count_d[0]] = '{inst: imem_rdata, pc: fetch_pc_q};
        count_d           = count_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      target_q   <= '0;
      ent_q[0]   <= '0;
      ent_q[1]   <= '0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
      ent_q[0]   <= ent_d[0];
      ent_q[1]   <= ent_d[1];
      count_q    <= count_d;
    end
  end

  assign if_valid       = (count_q != 2'd0);
  assign if_instruction = ent_q[0].inst;
  assign if_pc          = ent_q[0].pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The instruction memory returns {7'b0, addr};
// in fast mode it acknowledges in the request cycle, in slow mode three cycles
// after the request rises. Inputs change and outputs are sampled 1 ns after
// each rising clock edge.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic [INST_W-1:0] if_instruction;
  logic [PC_W-1:0]   if_pc;
  logic              if_valid;
  logic              if_stall;
  logic              redirect;
  logic [1:0]        redirect_sel;
  logic              redirect_call;
  logic [PC_W-1:0]   id_pc;
  logic [PC_W-1:0]   id_imm;
  logic              ras_overflow;
  logic              ras_underflow;

  int vectors     = 0;
  int miscompares = 0;

  logic       fast_mode;
  logic [1:0] wait_cnt;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(12'h000), .RAS_DEPTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_valid       (if_valid),
    .if_stall       (if_stall),
    .redirect       (redirect),
    .redirect_sel   (redirect_sel),
    .redirect_call  (redirect_call),
    .id_pc          (id_pc),
    .id_imm         (id_imm),
    .ras_overflow   (ras_overflow),
    .ras_underflow  (ras_underflow)
  );

  // Memory model
  assign imem_rdata = {7'b0, imem_addr};
  assign imem_ack   = fast_mode ? imem_req : (imem_req && wait_cnt == 2'd3);

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 2'd1;
    else                       wait_cnt <= 2'd0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},  imem_req, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_val"},  if_valid, 0);
    check({tag, "_pc"},   if_pc, 0);
    check({tag, "_inst"}, if_instruction, 0);
    check({tag, "_ovf"},  ras_overflow, 0);
    check({tag, "_unf"},  ras_underflow, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; if_stall = 1'b0; redirect = 1'b0; redirect_sel = SEL_NONE;
    redirect_call = 1'b0; id_pc = '0; id_imm = '0; fast_mode = 1'b1; wait_cnt = 2'd0;
    step(); step();
    check_reset_outputs("rst");

    // Release reset: first request at PC 0, head valid one cycle later.
    reset = 1'b0;
    #1;
    check("c1_req", imem_req, 1);
    check("c1_addr", imem_addr, 12'h000);
    step();
    check("c2_valid", if_valid, 1);
    check("c2_pc", if_pc, 12'h000);
    check("c2_inst", if_instruction, 19'h00000);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("stream_pc", if_pc, i);
      check("stream_inst", if_instruction, i);
    end

    // Stall 4 cycles with head at PC 5: queue fills with 5,6 and request drops.
    if_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", if_pc, 12'h005);
      check("stall_req", imem_req, 0);
    end
    step();
    if_stall = 1'b0;
    check("rel_pc5", if_pc, 12'h005);
    check("rel_req_off", imem_req, 0);
    step();
    check("rel_pc6", if_pc, 12'h006);
    check("rel_req_on", imem_req, 1);
    check("rel_addr7", imem_addr, 12'h007);
    step();
    check("rel_pc7", if_pc, 12'h007);

    // Branch: 10 + 1 + 0x20 = 43
    redirect = 1'b1; redirect_sel = SEL_BRANCH; id_pc = 12'd10; id_imm = 12'h020;
    step();
    redirect = 1'b0;
    check("br_flush", if_valid, 0);
    check("br_addr", imem_addr, 12'h02B);
    step();
    check("br_valid", if_valid, 1);
    check("br_pc", if_pc, 12'h02B);

    // Call then return
    redirect = 1'b1; redirect_sel = SEL_JUMP; redirect_call = 1'b1;
    id_pc = 12'h100; id_imm = 12'h300;
    step();
    redirect = 1'b0; redirect_call = 1'b0;
    check("call_flush", if_valid, 0);
    check("call_addr", imem_addr, 12'h300);
    step();
    check("call_pc", if_pc, 12'h300);
    redirect = 1'b1; redirect_sel = SEL_RET;
    step();
    redirect = 1'b0;
    check("ret_addr", imem_addr, 12'h101);
    step();
    check("ret_pc", if_pc, 12'h101);
    check("ret_ovf", ras_overflow, 0);
    check("ret_unf", ras_underflow, 0);

    // Nine calls into an 8-deep stack: pushes 0x201..0x209, 0x201 is lost.
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check("ovf_pre", ras_overflow, 0);
      redirect = 1'b1; redirect_sel = SEL_JUMP; redirect_call = 1'b1;
      id_pc = 12'h200 + 12'(i); id_imm = 12'h400;
      step();
    end
    redirect_call = 1'b0;
    check("ovf_set", ras_overflow, 1);

    // Eight returns unwind 0x209..0x202, the ninth finds the stack empty.
    for (int j = 0; j < 9; j++) begin
      if (j == 8) check("unf_pre", ras_underflow, 0);
      redirect = 1'b1; redirect_sel = SEL_RET;
      step();
      check("ret_tgt", imem_addr, (j < 8) ? (32'h209 - j) : 32'h0);
    end
    redirect = 1'b0;
    check("unf_set", ras_underflow, 1);
    check("unf_flush", if_valid, 0);
    step();
    check("unf_pc", if_pc, 12'h000);
    check("unf_valid", if_valid, 1);

    // sel=00 with redirect=1 is ignored: stream continues.
    redirect = 1'b1; redirect_sel = SEL_NONE; id_imm = 12'h555;
    step();
    redirect = 1'b0;
    check("sel0_valid", if_valid, 1);
    check("sel0_pc", if_pc, 12'h001);
    check("sel0_addr", imem_addr, 12'h002);

    // Slow memory: redirect in the first wait cycle, then re-target in DRAIN.
    fast_mode = 1'b0;
    redirect = 1'b1; redirect_sel = SEL_JUMP; id_imm = 12'h050;
    step();
    redirect = 1'b0;
    check("dr_req1", imem_req, 1);
    check("dr_addr1", imem_addr, 12'h002);
    check("dr_flush", if_valid, 0);
    step();
    redirect = 1'b1; redirect_sel = SEL_JUMP; id_imm = 12'h070;
    check("dr_addr2", imem_addr, 12'h002);
    step();
    redirect = 1'b0;
    check("dr_ack", imem_ack, 1);
    check("dr_addr3", imem_addr, 12'h002);
    step();
    fast_mode = 1'b1;
    check("dr_tgt", imem_addr, 12'h070);
    check("dr_discard", if_valid, 0);
    step();
    check("dr_pc", if_pc, 12'h070);

    // Redirect while stalled with a full queue.
    if_stall = 1'b1;
    step();
    check("full_req", imem_req, 0);
    check("full_pc", if_pc, 12'h070);
    redirect = 1'b1; redirect_sel = SEL_JUMP; id_imm = 12'h0A0;
    step();
    redirect = 1'b0; if_stall = 1'b0;
    check("fr_flush", if_valid, 0);
    check("fr_addr", imem_addr, 12'h0A0);
    step();
    check("fr_pc", if_pc, 12'h0A0);

    // Enter DRAIN, then pulse reset mid-request.
    fast_mode = 1'b0;
    redirect = 1'b1; redirect_sel = SEL_JUMP; id_imm = 12'h0B0;
    step();
    redirect = 1'b0;
    check("rd_req", imem_req, 1);
    check("rd_addr", imem_addr, 12'h0A1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    step();
    reset = 1'b0; fast_mode = 1'b1;
    #1;
    check("post_req", imem_req, 1);
    check("post_addr", imem_addr, 12'h000);
    step();
    check("post_valid", if_valid, 1);
    check("post_pc", if_pc, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register and feeds the datapath.
- Owns the fetch PC and a 2-entry instruction prefetch queue.
- Also owns the return-address stack and a handshaked instruction-memory port.
- Takes redirects (branch, jump, call, return) from ID and delivers {instruction, pc, valid} to IF/ID, honouring the hazard unit's stall.

Parameters:
RESET_PC, 12'h000, fetch PC after reset
RAS_DEPTH, 8, return-address stack entries (power of 2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
imem_req  out  1  fetch request; held with stable imem_addr until imem_ack
imem_addr  out  12  fetch address
imem_ack  in  1  read data valid this cycle; may be asserted in the same cycle as imem_req
imem_rdata  in  19  instruction word
if_instruction  out  19  queue head instruction
if_pc  out  12  PC of queue head
if_valid  out  1  queue head valid
if_stall  in  1  consumer hold; head not popped
redirect  in  1  one-cycle pulse from ID
redirect_sel  in  2  01 branch, 10 jump, 11 return (00 ignored)
redirect_call  in  1  with sel=10: push id_pc+1 onto the RAS
id_pc  in  12  PC of the redirecting instruction
id_imm  in  12  jump address [11:0] / branch offset [7:0]
ras_overflow  out  1  sticky: push while full
ras_underflow  out  1  sticky: pop while empty

Behaviour:
- Reset values: imem_req=0, imem_addr=0, if_instruction=0, if_pc=0, if_valid=0, ras_* flags=0, queue empty, RAS empty.
- State after reset is FETCH with fetch_pc=RESET_PC.
- States:
  - FETCH: imem_req=1 when queue count<2, imem_addr=fetch_pc. On ack: push {rdata, fetch_pc} into the queue and set fetch_pc+1 (mod 4096).
  - DRAIN: entered on redirect while a request is outstanding and imem_ack=0. imem_req stays high with the old imem_addr until ack. Ack data is discarded, then the block returns to FETCH at the latched target.
- Queue is show-ahead: the head drives if_* combinationally from registers.
- Pop when if_valid && !if_stall. Push and pop in the same cycle is allowed at any count.
- Latency: ack in cycle N gives if_valid=1 in cycle N+1. With a combinational memory and no stalls, throughput is 1 instruction per cycle.
- Full queue (count=2): imem_req drops; request resumes the cycle after a pop.
- Redirect target:
  - branch: id_pc+1+{4'b0,id_imm[7:0]} (zero-extended, wraps mod 4096)
  - jump: id_imm
  - return: RAS top
- Redirect has priority over if_stall and over any same-cycle push. At that edge:
  - queue flushed, so if_valid=0 next cycle
  - same-cycle ack data discarded
  - fetch_pc = target, or target latched if entering DRAIN
- Redirect during DRAIN replaces the latched target.
- RAS:
  - Call pushes id_pc+1.
  - Push when full overwrites the oldest entry (circular) and sets ras_overflow.
  - Return pops. Pop when empty yields target 0 and sets ras_underflow.
  - Flags clear only on reset.
- redirect_sel=00 with redirect=1: treated as no redirect.
- Reset asserted mid-request: imem_req drops immediately (asynchronous) and all state clears.

Decomposition:
- Shared package: redirect_sel encodings (SEL_BRANCH=2'b01, SEL_JUMP=2'b10, SEL_RET=2'b11), PC_W=12, INST_W=19, fetch state enum {FETCH, DRAIN}.
- One sub-module: ret_addr_stack (RAS_DEPTH, push/pop, top, overflow/underflow), reusable by the datapath.

Test Plan:
- Reset with RESET_PC=0 and a combinational memory returning {7'b0,pc}. Release reset → cycle 1: imem_addr=0. Cycle 2: if_valid=1, if_pc=0. Then one new PC per cycle.
- Hold if_stall=1 for 4 cycles from if_pc=5 → queue fills to 5,6; imem_req=0; if_pc stays 5. Release → 5,6,7 delivered with none lost or duplicated.
- Branch: redirect sel=01, id_pc=10, id_imm=8'h20 → next delivered if_pc=43 (12'h02B). Queued entries never reach if_valid.
- Call then return: sel=10, call=1, id_pc=12'h100, id_imm=12'h300 → fetch at 12'h300. Later sel=11 → fetch at 12'h101. Ninth push at RAS_DEPTH=8 sets ras_overflow=1. Pop on an empty RAS → target 0, ras_underflow=1.
- Slow memory (ack 3 cycles after req): redirect in the first wait cycle → imem_addr held until ack. That data is discarded and the next imem_addr equals the target.
- Redirect with if_stall=1 and a full queue → flush, if_valid=0 next cycle, fetch resumes at the target. Reset pulsed mid-DRAIN → all outputs return to reset values.
